fixed_point_booth_multiplier_param: RTL and testbench
=====================================================

Name: fixed_point_booth_multiplier_param

Overview:
- Parametrised sequential signed fixed-point multiplier using radix-4 (modified) Booth recoding, two multiplier bits per cycle.
- Next generation of the 16-bit fixed-point Booth multiplier used by the ODE accelerator datapath.
- Adds generic width and fraction position, optional saturation and rounding, edge-qualified start, and a busy indication.

Parameters:
- WIDTH, 16, operand and result width in bits, two's complement; must be even and at least 4.
- FRAC_BITS, 8, number of fractional bits (Q format); range 0..WIDTH-1.
- SATURATE, 1:
  - 1 clamps the result on overflow.
  - 0 returns the wrapped (truncated) bits.
- ROUND, 0:
  - 0 truncates toward minus infinity (arithmetic shift).
  - 1 rounds half up by adding bit FRAC_BITS-1 before the shift.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  multiplicand, signed Q(WIDTH-FRAC_BITS).FRAC_BITS.
- b  input  WIDTH  multiplier, same format.
- start  input  1  operation request; only its rising edge is acted on.
- result  output  WIDTH  product in the same Q format.
- overflow_flag  output  1  product not representable in WIDTH bits.
- finish  output  1  result and overflow_flag valid.
- busy  output  1  operation in progress.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; result=0, overflow_flag=0, finish=0, busy=0; accumulator, multiplier shift register and start_q cleared.
- Reset mid-operation aborts immediately. No partial result is ever shown.
- Start qualification:
  - start_q is a register holding the previous cycle's start.
  - A request is start=1 and start_q=0, sampled in IDLE or DONE.
  - start held high launches exactly one operation.
  - Requests while in RUN are ignored; they are not queued.
- States:
  - IDLE: waits for a request.
  - On a request from IDLE or DONE:
    - a and b are captured.
    - The accumulator (2*WIDTH bits) is cleared; finish drops to 0; busy goes to 1.
    - The state moves to RUN and the iteration counter is set to 0.
  - RUN, one radix-4 step per cycle:
    - The digit is selected from multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
    - Digit 0, +M, +2M, -M or -2M is applied, where M is a sign-extended to 2*WIDTH bits.
    - The partial product is shifted left by 2i and added to the accumulator.
    - The counter increments by 1.
  - When the counter reaches WIDTH/2-1: finalisation is done in the same cycle, then the state moves to DONE.
  - DONE: finish=1, busy=0. result and overflow_flag are held stable until the next request or reset.
- Latency: finish is high exactly WIDTH/2+1 rising edges after the request edge (9 for WIDTH=16).
- Finalisation, with P the full 2*WIDTH-bit signed product:
  - If ROUND=1 and FRAC_BITS>0, add 1<<(FRAC_BITS-1) to P.
  - S = P arithmetic-shifted right by FRAC_BITS.
  - Overflow occurs when bits S[2*WIDTH-1 : WIDTH-1] are not all equal.
  - Non-overflow: result = S[WIDTH-1:0].
  - Overflow with SATURATE=1: result = 0111..1 if P is non-negative, else 1000..0.
  - Overflow with SATURATE=0: result = S[WIDTH-1:0], overflow_flag=1.
- Edge cases:
  - a = b = most negative value: +2M of the most negative value must not lose its sign. The accumulator and M are kept at 2*WIDTH bits, so the product is exact.
  - The rounding add is done at 2*WIDTH+1 bits, so rounding cannot wrap P.

Decomposition:
- Package fixed_point_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Helper functions for Q-format MAX/MIN constants by width.
  - Booth digit encoding constants.
- Sub-module booth_radix4_encoder (combinational):
  - Inputs: 3 multiplier bits and M.
  - Output: the selected signed partial product (0, ±M, ±2M) at 2*WIDTH bits.
  - The parent block does the shifting, accumulation, counting and finalisation.

Test Plan (WIDTH=16, FRAC_BITS=8, SATURATE=1, ROUND=0 unless noted):
- a=0x0180 (1.5), b=0x0200 (2.0), pulse start -> after 9 edges finish=1, result=0x0300, overflow_flag=0, busy=0.
- a=0xFF00 (-1.0), b=0x0100 -> result=0xFF00, flag=0. a=0x8000, b=0x0100 -> result=0x8000, flag=0.
- Overflow, a=0x4000, b=0x0200 (128.0):
  - SATURATE=1 -> result=0x7FFF, flag=1.
  - SATURATE=0 -> result=0x8000, flag=1.
  - a=b=0x8000 -> result=0x7FFF, flag=1.
- Rounding, a=0x0001, b=0x0080:
  - ROUND=0 -> result=0x0000.
  - ROUND=1 -> result=0x0001.
  - Both with flag=0.
- Handshake:
  - start held high for 30 cycles -> exactly one operation; finish stays 1 with result stable.
  - A start pulse during RUN is ignored.
  - A new pulse in DONE drops finish on the next edge and restarts.
- Reset:
  - reset_n asserted at RUN cycle 4 -> outputs are 0 immediately (asynchronously).
  - After release, a new request completes correctly with the original 9-cycle latency.
- Random regression: 1000 random operand pairs checked against a bit-accurate reference model for every SATURATE/ROUND combination and for WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared state, Booth digit and Q-format helpers for the fixed-point multiplier
package fixed_point_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {DIG_ZERO, DIG_POS1, DIG_POS2, DIG_NEG1, DIG_NEG2} booth_digit_e;
  // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_digit_e booth_decode(input logic [2:0] bits);
    return (bits == 3'b001 || bits == 3'b010) ? DIG_POS1 :
           (bits == 3'b011)                   ? DIG_POS2 :
           (bits == 3'b100)                   ? DIG_NEG2 :
           (bits == 3'b101 || bits == 3'b110) ? DIG_NEG1 : DIG_ZERO;
  endfunction
  // Largest positive two's complement value of width w (w <= 64)
  function automatic logic [63:0] q_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  // Most negative two's complement value of width w, as its bit pattern
  function automatic logic [63:0] q_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/booth_radix4_encoder.sv
// booth_radix4_encoder: selects 0, +-M or +-2M from three multiplier bits
module booth_radix4_encoder
  import fixed_point_pkg::*;
#(
  parameter int PW = 32
) (
  input  logic [2:0]    bits,
  input  logic [PW-1:0] m,
  output logic [PW-1:0] pp
);
  booth_digit_e digit;
  // M is already sign-extended to PW bits, so 2M of the most negative operand keeps its sign
  always_comb begin
    digit = booth_decode(bits);
    pp = (digit == DIG_POS1) ? m :
         (digit == DIG_POS2) ? m << 1 :
         (digit == DIG_NEG1) ? -m :
         (digit == DIG_NEG2) ? -(m << 1) : '0;
  end
endmodule

// File: rtl/fixed_point_booth_multiplier_param.sv
// fixed_point_booth_multiplier_param: sequential radix-4 Booth signed Q-format multiplier
module fixed_point_booth_multiplier_param
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int SATURATE  = 1,
  parameter int ROUND     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             finish,
  output logic             busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(q_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(q_min(WIDTH));
  localparam logic [PW:0] RND = (ROUND != 0 && FRAC_BITS > 0) ?
    {{PW{1'b0}}, 1'b1} << (FRAC_BITS > 0 ? FRAC_BITS - 1 : 0) : '0;
  state_e state_q, state_d;
  logic start_q;
  logic [PW-1:0] m_q, m_d, acc_q, acc_d, pp, acc_sum;
  logic [WIDTH-1:0] b_q, b_d, result_q, result_d;
  logic prev_q, prev_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW:0] p_ext;
  logic signed [PW:0] s;
  logic req, last, ovf;
  booth_radix4_encoder #(.PW(PW)) u_enc (
    .bits({b_q[1:0], prev_q}),
    .m   (m_q),
    .pp  (pp)
  );
  // Accumulate, shift M/b by one digit per step, and finalise on the last digit
  always_comb begin
    req = start && !start_q && state_q != RUN;
    last = cnt_q == CW'(WIDTH / 2 - 1);
    acc_sum = acc_q + pp;
    p_ext = {acc_sum[PW-1], acc_sum} + RND;
    s = $signed(p_ext) >>> FRAC_BITS;
    ovf = !(&s[PW:WIDTH-1] || ~|s[PW:WIDTH-1]);
    state_d = state_q;
    m_d = m_q;
    b_d = b_q;
    prev_d = prev_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    result_d = result_q;
    ovf_d = ovf_q;
    if (req) begin
      state_d = RUN;
      m_d = {{WIDTH{a[WIDTH-1]}}, a};
      b_d = b;
      prev_d = 1'b0;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_sum;
      m_d = m_q << 2;
      b_d = b_q >> 2;
      prev_d = b_q[1];
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        ovf_d = ovf;
        result_d = (ovf && SATURATE != 0) ? (acc_sum[PW-1] ? SAT_MIN : SAT_MAX) : s[WIDTH-1:0];
      end
    end
  end
  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      m_q <= '0;
      b_q <= '0;
      prev_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      m_q <= m_d;
      b_q <= b_d;
      prev_q <= prev_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      ovf_q <= ovf_d;
    end
  end
  assign result = result_q;
  assign overflow_flag = ovf_q;
  assign finish = state_q == DONE;
  assign busy = state_q == RUN;
endmodule

// File: tb/tb_fixed_point_booth_multiplier_param.sv
// tb_fixed_point_booth_multiplier_param: scoreboard bench over a saturating/truncating and a wrapping/rounding instance
module tb_fixed_point_booth_multiplier_param;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r0;
    logic        f0;
    logic [15:0] r1;
    logic        f1;
  } vec_t;
  typedef struct packed {
    logic [15:0] r0;
    logic        f0;
    logic [15:0] r1;
    logic        f1;
  } exp_t;

  logic clk = 0, reset_n = 0, start = 0;
  logic [15:0] a = 0, b = 0;
  logic [15:0] res_a, res_b;
  logic ovf_a, ovf_b, fin_a, fin_b, busy_a, busy_b;
  int tests = 0, fails = 0, ops_done = 0;
  logic fin_prev = 0;
  exp_t exp_q[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  fixed_point_booth_multiplier_param #(.WIDTH(16), .FRAC_BITS(8), .SATURATE(1), .ROUND(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .start(start),
    .result(res_a), .overflow_flag(ovf_a), .finish(fin_a), .busy(busy_a));
  fixed_point_booth_multiplier_param #(.WIDTH(16), .FRAC_BITS(8), .SATURATE(0), .ROUND(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .start(start),
    .result(res_b), .overflow_flag(ovf_b), .finish(fin_b), .busy(busy_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: on each rising finish, pop the expected response and compare both instances
  always @(negedge clk) begin
    if (fin_a && !fin_prev) begin
      ops_done++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_finish: result %h with empty scoreboard", res_a);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sat_result", res_a, e.r0);
        chk("sat_flag", ovf_a, e.f0);
        chk("wrap_round_result", res_b, e.r1);
        chk("wrap_round_flag", ovf_b, e.f1);
        chk("busy_at_finish", busy_a, 0);
        chk("finish_in_step", fin_b, 1);
      end
    end
    fin_prev = fin_a;
  end

  task automatic start_op(input vec_t v, input logic push);
    @(posedge clk);
    #1;
    a = v.a;
    b = v.b;
    start = 1;
    if (push) exp_q.push_back('{v.r0, v.f0, v.r1, v.f1});
  endtask

  task automatic wait_finish(output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      start = 0;
      n++;
      if (fin_a) break;
      if (n >= 40) begin
        tests++;
        fails++;
        $display("FAIL finish_timeout: no finish after %0d edges", n);
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    start_op(v, 1);
    wait_finish(n);
    chk(nm, n, 9);
    @(posedge clk);
  endtask

  initial begin
    int n, d0;
    // a, b, SAT/trunc result+flag, wrap/round result+flag
    vecs = '{
      '{16'h0180, 16'h0200, 16'h0300, 1'b0, 16'h0300, 1'b0},
      '{16'hFF00, 16'h0100, 16'hFF00, 1'b0, 16'hFF00, 1'b0},
      '{16'h8000, 16'h0100, 16'h8000, 1'b0, 16'h8000, 1'b0},
      '{16'h4000, 16'h0200, 16'h7FFF, 1'b1, 16'h8000, 1'b1},
      '{16'h8000, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1},
      '{16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0001, 1'b0},
      '{16'hFFFF, 16'h0080, 16'hFFFF, 1'b0, 16'h0000, 1'b0},
      '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'hFF00, 1'b1},
      '{16'h0300, 16'hFE00, 16'hFA00, 1'b0, 16'hFA00, 1'b0},
      '{16'hC000, 16'h0200, 16'h8000, 1'b0, 16'h8000, 1'b0},
      '{16'hC000, 16'h0201, 16'h8000, 1'b1, 16'h7FC0, 1'b1},
      '{16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0}
    };
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", res_a, 0);
    chk("reset_flag", ovf_a, 0);
    chk("reset_finish", fin_a, 0);
    chk("reset_busy", busy_a, 0);
    reset_n = 1;
    foreach (vecs[i]) run_vec(vecs[i], "latency");
    // start held high for 30 cycles launches exactly one operation
    d0 = ops_done;
    start_op(vecs[0], 1);
    repeat (30) @(posedge clk);
    #1;
    chk("held_start_ops", ops_done - d0, 1);
    chk("held_start_finish", fin_a, 1);
    chk("held_start_result", res_a, vecs[0].r0);
    start = 0;
    @(posedge clk);
    // a pulse during RUN is ignored
    d0 = ops_done;
    start_op(vecs[8], 1);
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(posedge clk);
    #1;
    a = 16'h0100;
    b = 16'h0100;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_finish(n);
    chk("run_pulse_latency", n, 5);
    repeat (12) @(posedge clk);
    #1;
    chk("run_pulse_ops", ops_done - d0, 1);
    chk("run_pulse_finish", fin_a, 1);
    chk("run_pulse_result", res_a, vecs[8].r0);
    // a new pulse in DONE drops finish on the next edge and restarts
    start_op(vecs[3], 1);
    @(posedge clk);
    #1 start = 0;
    chk("restart_finish_low", fin_a, 0);
    chk("restart_busy", busy_a, 1);
    wait_finish(n);
    chk("restart_latency", n, 8);
    @(posedge clk);
    // asynchronous reset in the middle of RUN
    start_op(vecs[7], 0);
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_before_reset", busy_a, 1);
    reset_n = 0;
    #1;
    chk("abort_result", res_a, 0);
    chk("abort_flag", ovf_a, 0);
    chk("abort_finish", fin_a, 0);
    chk("abort_busy", busy_a, 0);
    @(posedge clk);
    #1 reset_n = 1;
    run_vec(vecs[10], "post_reset_latency");
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
